// File: rtl/hybrid_out_serializer.sv
// ---------------------------------------------------------------------------------------------
// hybrid_out_serializer
//
// Output-side companion of the hybrid transform core. Every in_data_valid strobe is carried
// through a delay line that matches the core's pipeline latency. When the strobe reaches the
// tail, the core's 8-lane parallel result is captured into a small circular frame buffer. The
// head frame is then streamed out one lane per cycle over a valid/ready handshake.
//
// Parameters
//   CORE_LATENCY  cycles from an in_data_valid strobe to a valid core output (>= 1)
//   FRAME_DEPTH   number of whole frames buffered (power of two, >= 2)
//
// Ports
//   CLK            clock, rising edge
//   RESET          asynchronous, active-high reset
//   in_data_valid  strobe driven to the core input
//   t_select       transform mode; sampled together with in_data_valid
//   rI0..rI7       core real outputs, 12 bits each
//   iI0..iI7       core imaginary outputs, 12 bits each
//   out_valid      the sample on out_real/out_imag is valid (buffer not empty)
//   out_ready      consumer accepts the current sample
//   out_real       real part of the current sample
//   out_imag       imaginary part of the current sample
//   out_index      lane number 0..7 of the current sample
//   out_last       high with lane 7
//   out_mode       t_select of the frame being streamed
//   overflow       sticky; set when a frame is dropped because the buffer is full
//
// Build option
//   HYBRID_SER_IMAG_EN  when defined, imaginary lanes are stored and streamed on out_imag.
//                       When undefined, iI0..iI7 are ignored, no imaginary storage is built,
//                       and out_imag is constant 0.
// ---------------------------------------------------------------------------------------------
module hybrid_out_serializer #(
   parameter int unsigned CORE_LATENCY = 6,
   parameter int unsigned FRAME_DEPTH  = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        in_data_valid,
   input  logic [1:0]  t_select,
   input  logic [11:0] rI0,
   input  logic [11:0] rI1,
   input  logic [11:0] rI2,
   input  logic [11:0] rI3,
   input  logic [11:0] rI4,
   input  logic [11:0] rI5,
   input  logic [11:0] rI6,
   input  logic [11:0] rI7,
   input  logic [11:0] iI0,
   input  logic [11:0] iI1,
   input  logic [11:0] iI2,
   input  logic [11:0] iI3,
   input  logic [11:0] iI4,
   input  logic [11:0] iI5,
   input  logic [11:0] iI6,
   input  logic [11:0] iI7,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_real,
   output logic [11:0] out_imag,
   output logic [2:0]  out_index,
   output logic        out_last,
   output logic [1:0]  out_mode,
   output logic        overflow
);

   localparam int unsigned PtrW = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FRAME_DEPTH + 1);
   // Each delay-line entry is {valid, mode[1:0]}; the newest entry sits in the low bits.
   localparam int unsigned DlyW = 3 * CORE_LATENCY;

   // ------------------------------------------------------------------------------------------
   // Delay line: tracks strobes and their mode through the core latency
   // ------------------------------------------------------------------------------------------
   logic [DlyW-1:0] dly_q;
   logic [DlyW-1:0] dly_d;
   logic            cap;
   logic [1:0]      cap_mode;

   if (CORE_LATENCY == 1) begin : g_dly_single
      assign dly_d = {in_data_valid, t_select};
   end else begin : g_dly_multi
      assign dly_d = {dly_q[DlyW-4:0], in_data_valid, t_select};
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dly_q <= '0;
      end else begin
         dly_q <= dly_d;
      end
   end

   // Tail entry: the core result is valid on its inputs during this cycle.
   assign cap      = dly_q[DlyW-1];
   assign cap_mode = dly_q[DlyW-2 -: 2];

   // ------------------------------------------------------------------------------------------
   // Buffer control
   // ------------------------------------------------------------------------------------------
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] occ_q;
   logic [2:0]      idx_q;
   logic            overflow_q;

   logic            full;
   logic            hs;
   logic            pop;
   logic            push;
   logic            drop;

   assign full      = (occ_q == CntW'(FRAME_DEPTH));
   assign out_valid = (occ_q != '0);
   assign hs        = out_valid && out_ready;
   assign pop       = hs && (idx_q == 3'd7);
   // A full buffer still accepts a capture when the head frame leaves in the same cycle.
   assign push      = cap && (!full || pop);
   assign drop      = cap && full && !pop;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         idx_q      <= 3'd0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            if (wr_ptr_q == PtrW'(FRAME_DEPTH - 1)) begin
               wr_ptr_q <= '0;
            end else begin
               wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
         end

         if (pop) begin
            if (rd_ptr_q == PtrW'(FRAME_DEPTH - 1)) begin
               rd_ptr_q <= '0;
            end else begin
               rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
         end

         if (push && !pop) begin
            occ_q <= occ_q + CntW'(1);
         end else if (pop && !push) begin
            occ_q <= occ_q - CntW'(1);
         end

         // Lane counter wraps 7 -> 0 by itself, exactly when the head frame is popped.
         if (hs) begin
            idx_q <= idx_q + 3'd1;
         end

         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign overflow = overflow_q;

   // ------------------------------------------------------------------------------------------
   // Frame storage (data only, no reset needed: reads are masked while the buffer is empty)
   // ------------------------------------------------------------------------------------------
   logic [7:0][11:0] mem_real_q [FRAME_DEPTH];
   logic [1:0]       mem_mode_q [FRAME_DEPTH];
   logic [11:0]      head_real;
   logic [11:0]      head_imag;
   logic [1:0]       head_mode;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_real_q[wr_ptr_q] <= {rI7, rI6, rI5, rI4, rI3, rI2, rI1, rI0};
         mem_mode_q[wr_ptr_q] <= cap_mode;
      end
   end

   assign head_real = mem_real_q[rd_ptr_q][idx_q];
   assign head_mode = mem_mode_q[rd_ptr_q];

`ifdef HYBRID_SER_IMAG_EN
   logic [7:0][11:0] mem_imag_q [FRAME_DEPTH];

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_imag_q[wr_ptr_q] <= {iI7, iI6, iI5, iI4, iI3, iI2, iI1, iI0};
      end
   end

   assign head_imag = mem_imag_q[rd_ptr_q][idx_q];
`else
   // Imaginary lanes are not stored in this build; the ports stay for pin compatibility.
   logic unused_imag;
   assign unused_imag = ^{iI7, iI6, iI5, iI4, iI3, iI2, iI1, iI0};
   assign head_imag   = 12'd0;
`endif

   // ------------------------------------------------------------------------------------------
   // Output mux: combinational from the head frame and lane counter, zero while empty
   // ------------------------------------------------------------------------------------------
   always_comb begin
      out_real  = 12'd0;
      out_imag  = 12'd0;
      out_index = 3'd0;
      out_last  = 1'b0;
      out_mode  = 2'b00;
      if (out_valid) begin
         out_real  = head_real;
         out_imag  = head_imag;
         out_index = idx_q;
         out_last  = (idx_q == 3'd7);
         out_mode  = head_mode;
      end
   end

endmodule

// File: tb/tb_hybrid_out_serializer.sv
module tb_hybrid_out_serializer;

   localparam int Lat   = 6;
   localparam int Depth = 2;
`ifdef HYBRID_SER_IMAG_EN
   localparam bit ImagEn = 1'b1;
`else
   localparam bit ImagEn = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic        in_data_valid;
   logic [1:0]  t_select;
   logic [11:0] r_in [8];
   logic [11:0] i_in [8];
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_real;
   logic [11:0] out_imag;
   logic [2:0]  out_index;
   logic        out_last;
   logic [1:0]  out_mode;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   hybrid_out_serializer #(
      .CORE_LATENCY (Lat),
      .FRAME_DEPTH  (Depth)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .in_data_valid (in_data_valid),
      .t_select      (t_select),
      .rI0           (r_in[0]),
      .rI1           (r_in[1]),
      .rI2           (r_in[2]),
      .rI3           (r_in[3]),
      .rI4           (r_in[4]),
      .rI5           (r_in[5]),
      .rI6           (r_in[6]),
      .rI7           (r_in[7]),
      .iI0           (i_in[0]),
      .iI1           (i_in[1]),
      .iI2           (i_in[2]),
      .iI3           (i_in[3]),
      .iI4           (i_in[4]),
      .iI5           (i_in[5]),
      .iI6           (i_in[6]),
      .iI7           (i_in[7]),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_real      (out_real),
      .out_imag      (out_imag),
      .out_index     (out_index),
      .out_last      (out_last),
      .out_mode      (out_mode),
      .overflow      (overflow)
   );

   // ------------------------------------------------------------------------------------------
   // Reference model: a queue of pending strobes (due cycle + mode) and a queue of whole frames
   // ------------------------------------------------------------------------------------------
   typedef struct packed {
      logic [1:0]       mode;
      logic [7:0][11:0] re;
      logic [7:0][11:0] im;
   } frame_t;

   frame_t      fq[$];
   int unsigned due_q[$];
   logic [1:0]  smode_q[$];
   int          m_lane;
   bit          m_ovf;
   int unsigned cyc;

   function automatic void chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   function automatic logic [31:0] got_vec();
      return {out_valid, out_real, out_imag, out_index, out_last, out_mode, overflow};
   endfunction

   function automatic logic [31:0] exp_vec();
      logic        v;
      logic [11:0] re;
      logic [11:0] im;
      logic [2:0]  ix;
      logic        l;
      logic [1:0]  md;
      v  = (fq.size() > 0);
      re = 12'd0;
      im = 12'd0;
      ix = 3'd0;
      l  = 1'b0;
      md = 2'b00;
      if (v) begin
         re = fq[0].re[m_lane];
         im = ImagEn ? fq[0].im[m_lane] : 12'd0;
         ix = 3'(m_lane);
         l  = (m_lane == 7);
         md = fq[0].mode;
      end
      return {v, re, im, ix, l, md, m_ovf};
   endfunction

   task automatic model_reset();
      fq.delete();
      due_q.delete();
      smode_q.delete();
      m_lane = 0;
      m_ovf  = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_edge();
      bit         cap;
      bit         hs;
      bit         pop;
      int         n;
      logic [1:0] cmode;
      frame_t     f;
      n     = fq.size();
      cap   = 1'b0;
      cmode = 2'b00;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         cap   = 1'b1;
         cmode = smode_q[0];
         void'(due_q.pop_front());
         void'(smode_q.pop_front());
      end
      if (in_data_valid) begin
         due_q.push_back(cyc + Lat);
         smode_q.push_back(t_select);
      end
      hs  = (n > 0) && out_ready;
      pop = hs && (m_lane == 7);
      if (hs) begin
         if (m_lane == 7) begin
            void'(fq.pop_front());
            m_lane = 0;
         end else begin
            m_lane++;
         end
      end
      if (cap) begin
         if (n < Depth || pop) begin
            for (int k = 0; k < 8; k++) begin
               f.re[k] = r_in[k];
               f.im[k] = i_in[k];
            end
            f.mode = cmode;
            fq.push_back(f);
         end else begin
            m_ovf = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLK);
      #1;
      chk($sformatf("model cyc %0d", cyc), got_vec(), exp_vec());
   endtask

   task automatic set_data(logic [11:0] rb, logic [11:0] ib);
      for (int k = 0; k < 8; k++) begin
         r_in[k] = rb + 12'(k);
         i_in[k] = ib + 12'(k);
      end
   endtask

   // Reset asserted between edges; outputs must clear without waiting for the clock.
   task automatic async_reset();
      RESET         = 1'b1;
      in_data_valid = 1'b0;
      #1;
      chk("async reset outputs zero", got_vec(), 0);
      model_reset();
      @(posedge CLK);
      #1;
      cyc++;
      RESET = 1'b0;
   endtask

   // Strobe now, present the core data Lat edges later; returns right after the capture edge.
   task automatic send_frame(logic [1:0] m, logic [11:0] rb, logic [11:0] ib);
      in_data_valid = 1'b1;
      t_select      = m;
      set_data(12'hE00, 12'hF00);
      tick();
      in_data_valid = 1'b0;
      t_select      = 2'b00;
      repeat (Lat - 1) tick();
      set_data(rb, ib);
      tick();
      set_data(12'hE00, 12'hF00);
   endtask

   task automatic wait_idx(int want);
      int n;
      n = 0;
      while (!(out_valid && int'(out_index) == want) && n < 40) begin
         tick();
         n++;
      end
      chk($sformatf("reach lane %0d", want), int'(out_valid && int'(out_index) == want), 1);
   endtask

   task automatic idle(int n);
      in_data_valid = 1'b0;
      repeat (n) tick();
   endtask

   // ------------------------------------------------------------------------------------------
   // Single-frame vector table
   // ------------------------------------------------------------------------------------------
   typedef struct {
      bit          idv;
      logic [1:0]  tsel;
      bit          data;
      bit          rdy;
      bit          ev;
      logic [11:0] er;
      logic [11:0] ei;
      logic [2:0]  ex;
      bit          el;
      logic [1:0]  em;
   } vec_t;

   vec_t tbl [15];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;

      for (int r = 0; r < 15; r++) begin
         tbl[r].idv  = (r == 0);
         tbl[r].tsel = (r == 0) ? 2'b10 : 2'b01;
         tbl[r].data = (r == Lat);
         tbl[r].rdy  = 1'b1;
         tbl[r].ev   = (r >= 6 && r <= 13);
         tbl[r].er   = tbl[r].ev ? 12'(12'h100 + r - 6) : 12'd0;
         tbl[r].ei   = tbl[r].ev ? 12'(12'h200 + r - 6) : 12'd0;
         tbl[r].ex   = tbl[r].ev ? 3'(r - 6) : 3'd0;
         tbl[r].el   = (r == 13);
         tbl[r].em   = tbl[r].ev ? 2'b10 : 2'b00;
      end

      RESET         = 1'b1;
      in_data_valid = 1'b0;
      t_select      = 2'b00;
      out_ready     = 1'b0;
      set_data(12'd0, 12'd0);
      cyc = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk("reset state", got_vec(), 0);
      RESET = 1'b0;
      idle(2);

      // 1. Single frame from the table
      for (int r = 0; r < 15; r++) begin
         in_data_valid = tbl[r].idv;
         t_select      = tbl[r].tsel;
         out_ready     = tbl[r].rdy;
         if (tbl[r].data) set_data(12'h100, 12'h200);
         else             set_data(12'hA00, 12'hB00);
         tick();
         chk($sformatf("t1 valid r%0d", r), out_valid, tbl[r].ev);
         chk($sformatf("t1 real r%0d", r), out_real, tbl[r].er);
         chk($sformatf("t1 imag r%0d", r), out_imag, ImagEn ? tbl[r].ei : 12'd0);
         chk($sformatf("t1 index r%0d", r), out_index, tbl[r].ex);
         chk($sformatf("t1 last r%0d", r), out_last, tbl[r].el);
         chk($sformatf("t1 mode r%0d", r), out_mode, tbl[r].em);
      end
      idle(3);

      // 2. Backpressure at lane 3
      out_ready = 1'b1;
      send_frame(2'b01, 12'h300, 12'h380);
      wait_idx(3);
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("t2 hold valid", out_valid, 1);
         chk("t2 hold index", out_index, 3);
         chk("t2 hold real", out_real, 12'h303);
      end
      out_ready = 1'b1;
      for (int k = 4; k < 8; k++) begin
         tick();
         chk("t2 resume index", out_index, k);
         chk("t2 resume real", out_real, 12'h300 + k);
      end
      tick();
      chk("t2 drained", out_valid, 0);
      idle(3);

      // 3. Back-to-back frames, strobes 8 cycles apart
      out_ready = 1'b1;
      for (int t = 0; t < 24; t++) begin
         in_data_valid = (t == 0 || t == 8);
         t_select      = (t == 0) ? 2'b11 : 2'b01;
         if (t == 6)       set_data(12'h400, 12'h480);
         else if (t == 14) set_data(12'h500, 12'h580);
         else              set_data(12'hE00, 12'hF00);
         tick();
         if (t >= 6 && t <= 21) begin
            chk("t3 valid", out_valid, 1);
            chk("t3 index", out_index, (t - 6) % 8);
            chk("t3 real", out_real, ((t < 14) ? 12'h400 : 12'h500) + (t - 6) % 8);
            chk("t3 mode", out_mode, (t < 14) ? 3 : 1);
         end
         if (t == 22) chk("t3 drained", out_valid, 0);
      end
      idle(2);

      // 4. Overflow with the consumer stalled
      out_ready = 1'b0;
      for (int t = 0; t < 9; t++) begin
         in_data_valid = (t < 3);
         t_select      = 2'(t);
         if (t >= 6) set_data(12'h600 + 12'(t - 6) * 12'h100, 12'h050);
         else        set_data(12'hE00, 12'hF00);
         tick();
         if (t == 7) chk("t4 no overflow at 2 frames", overflow, 0);
         if (t == 8) chk("t4 overflow after 3rd", overflow, 1);
      end
      in_data_valid = 1'b0;
      out_ready     = 1'b1;
      for (int j = 0; j < 16; j++) begin
         chk("t4 drain valid", out_valid, 1);
         chk("t4 drain real", out_real, ((j < 8) ? 12'h600 : 12'h700) + j % 8);
         tick();
      end
      chk("t4 only two frames", out_valid, 0);
      chk("t4 overflow sticky", overflow, 1);
      idle(2);
      async_reset();
      idle(2);

      // 5. Full buffer, capture coincides with the lane-7 pop
      out_ready = 1'b1;
      cnt       = 0;
      for (int t = 0; t < 40; t++) begin
         in_data_valid = (t == 0 || t == 1 || t == 8);
         t_select      = 2'b10;
         if (t == 6)       set_data(12'h900, 12'h010);
         else if (t == 7)  set_data(12'hA00, 12'h020);
         else if (t == 14) set_data(12'hB00, 12'h030);
         else              set_data(12'hE00, 12'hF00);
         tick();
         if (out_valid) cnt++;
         if (t == 14) chk("t5 second frame head", out_real, 12'hA00);
         if (t == 22) chk("t5 third frame head", out_real, 12'hB00);
      end
      chk("t5 lanes delivered", cnt, 24);
      chk("t5 no overflow", overflow, 0);

      // 6. Reset in the middle of a frame
      out_ready = 1'b1;
      send_frame(2'b10, 12'hC00, 12'hC80);
      wait_idx(4);
      async_reset();
      idle(3);
      send_frame(2'b11, 12'hD00, 12'hD80);
      chk("t6 restart index", out_index, 0);
      chk("t6 restart real", out_real, 12'hD00);
      chk("t6 restart mode", out_mode, 3);
      cnt = 1;
      for (int j = 0; j < 10; j++) begin
         tick();
         if (out_valid) cnt++;
      end
      chk("t6 lanes after reset", cnt, 8);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (i == 1000 || i == 2000) async_reset();
         in_data_valid = ($urandom_range(0, 5) == 0);
         t_select      = 2'($urandom);
         out_ready     = (i < 1500) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         for (int k = 0; k < 8; k++) begin
            r_in[k] = 12'($urandom);
            i_in[k] = 12'($urandom);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
